// File: rtl/fft_buf_pkg.sv
// Shared sample-buffer types and sizes for the producer writer and FFT_block.
package fft_buf_pkg;

  localparam int SAMPLE_WIDTH = 16;
  localparam int N_SAMPLES    = 1024;
  localparam int ADDR_WIDTH   = $clog2(N_SAMPLES);

  typedef enum logic [1:0] {
    B_FREE,
    B_FILLING,
    B_FULL,
    B_BUSY
  } bank_st_t;

  typedef enum logic {
    W_FILL,
    W_WAIT_FREE
  } wr_st_t;

  typedef enum logic {
    RD_IDLE,
    RD_BUSY
  } rd_st_t;

endpackage

// File: rtl/sample_bank_ram.sv
// Two-bank sample store: one write port, one registered read port.
module sample_bank_ram #(
  parameter int DW = 16,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register is reset so read data is 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sample_pingpong_writer.sv
// Ping-pong capture of I2S samples into two banks handed to FFT_block.
module sample_pingpong_writer #(
  parameter  int SAMPLE_WIDTH = fft_buf_pkg::SAMPLE_WIDTH,
  parameter  int N_SAMPLES    = fft_buf_pkg::N_SAMPLES,
  localparam int ADDR_WIDTH   = $clog2(N_SAMPLES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SAMPLE_WIDTH-1:0] sample_i,
  input  logic                    sample_valid_i,
  output logic                    fft_start_o,
  input  logic                    fft_end_i,
  input  logic [ADDR_WIDTH-1:0]   fft_addr_i,
  output logic [SAMPLE_WIDTH-1:0] fft_data_o,
  output logic                    fft_bank_o,
  output logic                    fft_busy_o,
  output logic                    overrun_o,
  input  logic                    clear_overrun_i
);

  import fft_buf_pkg::*;

  bank_st_t              bank_q [2];
  bank_st_t              bank_d [2];
  wr_st_t                wst_q, wst_d;
  rd_st_t                rd_q, rd_d;
  logic                  wr_bank_q, wr_bank_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic                  fft_bank_q, fft_bank_d;
  logic                  start_q, start_d;
  logic                  busy_q, busy_d;
  logic                  ovr_q, ovr_d;
  logic                  we, drop, rel, other, pick, last;

  always_comb begin
    bank_d     = bank_q;
    wst_d      = wst_q;
    rd_d       = rd_q;
    wr_bank_d  = wr_bank_q;
    wr_ptr_d   = wr_ptr_q;
    fft_bank_d = fft_bank_q;
    start_d    = 1'b0;
    busy_d     = busy_q;
    we         = 1'b0;
    drop       = 1'b0;
    other      = ~wr_bank_q;
    pick       = ~wr_bank_q;
    last       = (wr_ptr_q == ADDR_WIDTH'(N_SAMPLES - 1));
    rel        = (rd_q == RD_BUSY) && fft_end_i;

    if (rel) begin
      bank_d[fft_bank_q] = B_FREE;
      busy_d             = 1'b0;
      rd_d               = RD_IDLE;
    end

    case (wst_q)
      W_FILL: begin
        if (sample_valid_i) begin
          we                = 1'b1;
          wr_ptr_d          = wr_ptr_q + 1'b1;
          bank_d[wr_bank_q] = B_FILLING;
          if (last) begin
            bank_d[wr_bank_q] = B_FULL;
            if (bank_q[other] == B_FREE ||
                (rel && fft_bank_q == other))
              wr_bank_d = other;
            else
              wst_d = W_WAIT_FREE;
          end
        end
      end
      W_WAIT_FREE: begin
        drop = sample_valid_i;
        if (rel && fft_bank_q == other) begin
          wr_bank_d = other;
          wst_d     = W_FILL;
        end
      end
      default: ;
    endcase

    // A release hands straight over to any frame already waiting.
    if (rd_d == RD_IDLE) begin
      pick = (bank_d[other] == B_FULL) ? other : wr_bank_q;
      if (bank_d[pick] == B_FULL) begin
        bank_d[pick] = B_BUSY;
        fft_bank_d   = pick;
        start_d      = 1'b1;
        busy_d       = 1'b1;
        rd_d         = RD_BUSY;
      end
    end

    ovr_d = drop | (ovr_q & ~clear_overrun_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q[0]  <= B_FREE;
      bank_q[1]  <= B_FREE;
      wst_q      <= W_FILL;
      rd_q       <= RD_IDLE;
      wr_bank_q  <= 1'b0;
      wr_ptr_q   <= '0;
      fft_bank_q <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      bank_q     <= bank_d;
      wst_q      <= wst_d;
      rd_q       <= rd_d;
      wr_bank_q  <= wr_bank_d;
      wr_ptr_q   <= wr_ptr_d;
      fft_bank_q <= fft_bank_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      ovr_q      <= ovr_d;
    end
  end

  sample_bank_ram #(
    .DW(SAMPLE_WIDTH),
    .AW(ADDR_WIDTH + 1)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .waddr({wr_bank_q, wr_ptr_q}),
    .wdata(sample_i),
    .raddr({fft_bank_q, fft_addr_i}),
    .rdata(fft_data_o)
  );

  assign fft_start_o = start_q;
  assign fft_bank_o  = fft_bank_q;
  assign fft_busy_o  = busy_q;
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_sample_pingpong_writer.sv
// Scoreboard bench for sample_pingpong_writer with a frame-level reference model.
module tb_sample_pingpong_writer;

  localparam int SW = 16;
  localparam int N  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [SW-1:0] sample_i = '0;
  logic          sample_valid_i = 1'b0;
  logic          fft_start_o;
  logic          fft_end_i = 1'b0;
  logic [AW-1:0] fft_addr_i = '0;
  logic [SW-1:0] fft_data_o;
  logic          fft_bank_o;
  logic          fft_busy_o;
  logic          overrun_o;
  logic          clear_overrun_i = 1'b0;

  always #5 clk = ~clk;

  sample_pingpong_writer #(
    .SAMPLE_WIDTH(SW),
    .N_SAMPLES   (N)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .fft_start_o    (fft_start_o),
    .fft_end_i      (fft_end_i),
    .fft_addr_i     (fft_addr_i),
    .fft_data_o     (fft_data_o),
    .fft_bank_o     (fft_bank_o),
    .fft_busy_o     (fft_busy_o),
    .overrun_o      (overrun_o),
    .clear_overrun_i(clear_overrun_i)
  );

  typedef struct {
    bit            start;
    bit            busy;
    bit            bank;
    bit            ovr;
    bit            rdv;
    logic [SW-1:0] rdd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: frames, ownership and drop rule at transaction level.
  bit            m_fill_bank;
  int            m_cnt;
  bit            m_wait;
  int            m_full[$];
  bit            m_busy;
  bit            m_bbank;
  bit            m_ovr;
  logic [SW-1:0] m_mem [2][N];

  function automatic void model_reset();
    m_fill_bank = 0;
    m_cnt       = 0;
    m_wait      = 0;
    m_full.delete();
    m_busy      = 0;
    m_bbank     = 0;
    m_ovr       = 0;
  endfunction

  function automatic bit occupied(bit b);
    bit r;
    r = m_busy && (m_bbank == b);
    foreach (m_full[i]) if (m_full[i] == int'(b)) r = 1;
    return r;
  endfunction

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endfunction

  task automatic cyc(bit sv, logic [SW-1:0] d, bit fe, bit clr,
                     logic [AW-1:0] a);
    exp_t e;
    bit   busy0, fb0, oth, rel, drop;
    int   pick, idx;
    @(negedge clk);
    sample_valid_i  = sv;
    sample_i        = d;
    fft_end_i       = fe;
    clear_overrun_i = clr;
    fft_addr_i      = a;
    busy0 = m_busy;
    fb0   = m_fill_bank;
    oth   = !fb0;
    rel   = m_busy && fe;
    drop  = 0;
    e.rdv = busy0;
    e.rdd = m_mem[m_bbank][a];
    if (m_wait) begin
      drop = sv;
      if (rel && m_bbank == oth) begin
        m_wait      = 0;
        m_fill_bank = oth;
      end
    end else if (sv) begin
      m_mem[fb0][m_cnt] = d;
      m_cnt++;
      if (m_cnt == N) begin
        m_cnt = 0;
        m_full.push_back(int'(fb0));
        if (!occupied(oth) || (rel && m_bbank == oth)) m_fill_bank = oth;
        else m_wait = 1;
      end
    end
    if (rel) m_busy = 0;
    e.start = 0;
    if (!m_busy && m_full.size() > 0) begin
      pick = (m_full.size() > 1) ? int'(oth) : m_full[0];
      idx  = -1;
      for (int i = 0; i < m_full.size(); i++)
        if (idx < 0 && m_full[i] == pick) idx = i;
      m_full.delete(idx);
      m_busy  = 1;
      m_bbank = pick[0];
      e.start = 1;
    end
    m_ovr  = drop ? 1'b1 : (clr ? 1'b0 : m_ovr);
    e.busy = m_busy;
    e.bank = m_bbank;
    e.ovr  = m_ovr;
    q.push_back(e);
  endtask

  task automatic idle(int n, logic [AW-1:0] a);
    for (int i = 0; i < n; i++) cyc(0, '0, 0, 0, a);
  endtask

  task automatic fill(int n, bit seq, int base);
    for (int i = 0; i < n; i++)
      cyc(1, seq ? SW'(base + i) : SW'($urandom), 0, 0, AW'(i));
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_start"}, 32'(fft_start_o), 0);
    chk({tag, "_busy"}, 32'(fft_busy_o), 0);
    chk({tag, "_bank"}, 32'(fft_bank_o), 0);
    chk({tag, "_ovr"}, 32'(overrun_o), 0);
    chk({tag, "_data"}, 32'(fft_data_o), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && q.size() > 0) begin
        e = q.pop_front();
        chk("start", 32'(fft_start_o), 32'(e.start));
        chk("busy", 32'(fft_busy_o), 32'(e.busy));
        chk("bank", 32'(fft_bank_o), 32'(e.bank));
        chk("overrun", 32'(overrun_o), 32'(e.ovr));
        if (e.rdv) chk("rdata", 32'(fft_data_o), 32'(e.rdd));
      end
    end
  end

  initial begin : stim
    model_reset();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // Frame 0..7 into bank 0, then read back a few addresses
    fill(N, 1, 0);
    cyc(0, '0, 0, 0, 3);
    idle(3, 5);

    // Second frame waits behind a busy bank until release
    fill(N, 1, 10);
    idle(2, 0);
    cyc(0, '0, 1, 0, 0);
    idle(3, 0);
    idle(2, 7);

    // Both banks occupied: drops, sticky overrun, clear priority
    fill(N, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, SW'($urandom), 0, 0, 0);
    idle(2, 1);
    cyc(0, '0, 0, 1, 0);
    cyc(1, SW'($urandom), 0, 1, 0);
    idle(1, 2);
    cyc(0, '0, 0, 1, 0);

    // Release lets writer resume; last write coincides with release
    cyc(0, '0, 1, 0, 0);
    idle(2, 4);
    fill(N - 1, 0, 0);
    cyc(1, SW'($urandom), 1, 0, 0);
    cyc(1, SW'($urandom), 0, 0, 6);
    idle(2, 3);

    // Async reset in the middle of a frame
    fill(4, 0, 0);
    idle(1, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    q.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    fill(N, 1, 100);
    cyc(0, '0, 0, 0, 3);
    idle(2, 0);

    // End pulse with no FFT ownership is ignored
    cyc(0, '0, 1, 0, 0);
    idle(1, 0);
    cyc(0, '0, 1, 0, 0);
    idle(2, 0);

    // Random traffic
    for (int i = 0; i < 600; i++)
      cyc(bit'($urandom_range(0, 1)), SW'($urandom),
          $urandom_range(0, 9) == 0, $urandom_range(0, 15) == 0,
          AW'($urandom));
    idle(2, 0);

    @(negedge clk);
    chk("drain", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
